// File: rtl/accu_rr_sched.sv
// Round-robin scheduler sharing one frame accumulator between NUM_CH channels.
// A grant is held for FRAME_LEN accepted samples, then the tagged sum is emitted.
module accu_rr_sched #(
    parameter int NUM_CH    = 4,
    parameter int DATA_W    = 8,
    parameter int FRAME_LEN = 4,
    parameter int SUM_W     = DATA_W + $clog2(FRAME_LEN)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_CH-1:0]          req_valid,
    input  logic [NUM_CH*DATA_W-1:0]   req_data,
    output logic [NUM_CH-1:0]          req_ready,
    output logic                       valid_out,
    output logic [SUM_W-1:0]           data_out,
    output logic [$clog2(NUM_CH)-1:0]  chan_out,
    output logic                       busy
);
    localparam int CH_W  = $clog2(NUM_CH);
    localparam int CNT_W = $clog2(FRAME_LEN);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

    // Handshake: a sample moves on a rising edge where req_valid[i] and
    // req_ready[i] are both high; req_ready is only ever high for the granted channel.
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t            r_state;
    logic [CH_W-1:0]   r_ptr;
    logic [CH_W-1:0]   r_grant;
    logic [CNT_W-1:0]  r_count;
    logic [SUM_W-1:0]  r_acc;
    logic [NUM_CH-1:0] r_ready;
    logic              r_valid_out;
    logic [SUM_W-1:0]  r_data_out;
    logic [CH_W-1:0]   r_chan_out;
    logic              r_busy;

    logic              w_any;
    logic [CH_W-1:0]   w_pick;
    logic [CH_W:0]     w_sum;
    logic [CH_W-1:0]   w_idx;
    logic [DATA_W-1:0] w_sample;
    logic [SUM_W-1:0]  w_ext;
    logic              w_accept;

    // Search upward from the pointer with wrap; the first requester wins.
    always_comb begin
        w_any  = 1'b0;
        w_pick = '0;
        w_sum  = '0;
        w_idx  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_sum = {1'b0, r_ptr} + (CH_W+1)'(i);
            if (w_sum >= (CH_W+1)'(NUM_CH))
                w_sum = w_sum - (CH_W+1)'(NUM_CH);
            w_idx = w_sum[CH_W-1:0];
            if (!w_any && req_valid[w_idx]) begin
                w_any  = 1'b1;
                w_pick = w_idx;
            end
        end
    end

    always_comb begin
        w_sample = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (r_grant == CH_W'(c))
                w_sample = req_data[c*DATA_W +: DATA_W];
        end
    end

    assign w_ext    = SUM_W'(w_sample);
    assign w_accept = req_valid[r_grant] && r_ready[r_grant];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_grant     <= '0;
            r_count     <= '0;
            r_acc       <= '0;
            r_ready     <= '0;
            r_valid_out <= 1'b0;
            r_data_out  <= '0;
            r_chan_out  <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_valid_out <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_grant <= w_pick;
                        r_ready <= NUM_CH'(1) << w_pick;
                        r_busy  <= 1'b1;
                        r_state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (w_accept) begin
                        // First sample of a frame overwrites, so no separate clear is needed.
                        r_acc <= (r_count == '0) ? w_ext : r_acc + w_ext;
                        if (r_count == LAST_CNT) begin
                            r_count     <= '0;
                            r_ready     <= '0;
                            r_valid_out <= 1'b1;
                            r_data_out  <= r_acc + w_ext;
                            r_chan_out  <= r_grant;
                            r_state     <= S_DONE;
                        end else begin
                            r_count <= r_count + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    r_ptr   <= (r_grant == CH_W'(NUM_CH - 1)) ? '0 : r_grant + 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready = r_ready;
    assign valid_out = r_valid_out;
    assign data_out  = r_data_out;
    assign chan_out  = r_chan_out;
    assign busy      = r_busy;

endmodule

// File: tb/tb_accu_rr_sched.sv
// Directed bench for accu_rr_sched: hand-computed frame sums, channel order,
// frame period, stall handling, mid-frame reset and idle behaviour.
module tb_accu_rr_sched;
    localparam int NUM_CH = 4;
    localparam int DATA_W = 8;
    localparam int SUM_W  = 10;
    localparam int CH_W   = 2;
    localparam int W      = CH_W + SUM_W;

    logic                     clk;
    logic                     rst_n;
    logic [NUM_CH-1:0]        req_valid;
    logic [NUM_CH*DATA_W-1:0] req_data;
    logic [NUM_CH-1:0]        req_ready;
    logic                     valid_out;
    logic [SUM_W-1:0]         data_out;
    logic [CH_W-1:0]          chan_out;
    logic                     busy;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] got_q[$];
    int           stamp_q[$];

    accu_rr_sched #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .FRAME_LEN(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .valid_out (valid_out),
        .data_out  (data_out),
        .chan_out  (chan_out),
        .busy      (busy)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Output monitor, sampled 2 time units after each rising edge.
    always @(posedge clk) begin
        #2;
        check("ready_at_most_one", ($countones(req_ready) <= 1), 1);
        if (valid_out) begin
            got_q.push_back({chan_out, data_out});
            stamp_q.push_back(cyc);
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        got_q.delete();
        stamp_q.delete();
        exp_q.delete();
    endtask

    // Present one sample on channel ch and return on the negedge after it is accepted.
    task automatic send(input int ch, input logic [DATA_W-1:0] val);
        int b;
        req_valid[ch] = 1'b1;
        req_data[ch*DATA_W +: DATA_W] = val;
        b = 0;
        while (!req_ready[ch] && b < 50) begin
            @(negedge clk);
            b++;
        end
        check("send_ready", req_ready[ch], 1'b1);
        @(negedge clk);
    endtask

    task automatic wait_frames(input int n, input int budget);
        int b;
        b = 0;
        while (got_q.size() < n && b < budget) begin
            @(negedge clk);
            b++;
        end
        check("frame_count", got_q.size(), n);
    endtask

    task automatic score(input string tag);
        logic [W-1:0] e;
        logic [W-1:0] g;
        check({tag, "_nframes"}, got_q.size(), exp_q.size());
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            check({tag, "_frame"}, g, e);
        end
        exp_q.delete();
        got_q.delete();
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_valid_out", valid_out, 0);
        check("rst_data_out", data_out, 0);
        check("rst_chan_out", chan_out, 0);
        check("rst_ready", req_ready, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;

        // Channel 0 alone: 10,20,30,40 back-to-back, cycle by cycle
        @(negedge clk);
        req_valid[0] = 1'b1;
        req_data[7:0] = 8'd10;
        check("t1_ready_pre", req_ready, 0);
        @(negedge clk);
        check("t1_ready_c1", req_ready, 4'b0001);
        check("t1_busy", busy, 1);
        @(negedge clk);
        check("t1_ready_c2", req_ready, 4'b0001);
        req_data[7:0] = 8'd20;
        @(negedge clk);
        check("t1_ready_c3", req_ready, 4'b0001);
        req_data[7:0] = 8'd30;
        @(negedge clk);
        check("t1_ready_c4", req_ready, 4'b0001);
        req_data[7:0] = 8'd40;
        @(negedge clk);
        check("t1_valid_out", valid_out, 1);
        check("t1_data_out", data_out, 100);
        check("t1_chan_out", chan_out, 0);
        check("t1_ready_done", req_ready, 0);
        check("t1_busy_done", busy, 1);
        req_valid = '0;
        @(negedge clk);
        check("t1_valid_drop", valid_out, 0);
        check("t1_busy_idle", busy, 0);
        check("t1_data_hold", data_out, 100);

        // All channels saturated at 255: order 0,1,2,3,0, period 6
        do_reset();
        req_data  = {4{8'd255}};
        req_valid = 4'b1111;
        exp_q.push_back({2'd0, 10'd1020});
        exp_q.push_back({2'd1, 10'd1020});
        exp_q.push_back({2'd2, 10'd1020});
        exp_q.push_back({2'd3, 10'd1020});
        exp_q.push_back({2'd0, 10'd1020});
        wait_frames(5, 100);
        req_valid = '0;
        for (int i = 1; i < stamp_q.size(); i++)
            check("t2_period", stamp_q[i] - stamp_q[i-1], 6);
        score("t2");

        // Pointer moved to 2 by a channel-1 frame; then channels 0 and 3 compete
        do_reset();
        send(1, 8'd1);
        send(1, 8'd2);
        send(1, 8'd3);
        send(1, 8'd4);
        req_valid[1] = 1'b0;
        req_data[7:0]   = 8'd9;
        req_data[31:24] = 8'd7;
        req_valid[0] = 1'b1;
        req_valid[3] = 1'b1;
        exp_q.push_back({2'd1, 10'd10});
        exp_q.push_back({2'd3, 10'd28});
        exp_q.push_back({2'd0, 10'd36});
        wait_frames(3, 100);
        req_valid = '0;
        score("t3");

        // Channel 1 stalls mid-frame while channel 2 waits; channel 3 data is X
        do_reset();
        req_data[31:24] = 'x;
        req_data[23:16] = 8'd50;
        req_valid[2] = 1'b1;
        send(1, 8'd5);
        req_valid[1] = 1'b0;
        for (int i = 0; i < 7; i++) begin
            check("t4_stall_ready1", req_ready[1], 1);
            check("t4_stall_ready2", req_ready[2], 0);
            @(negedge clk);
        end
        send(1, 8'd6);
        check("t4_ready2_mid", req_ready[2], 0);
        send(1, 8'd7);
        send(1, 8'd8);
        req_valid[1] = 1'b0;
        exp_q.push_back({2'd1, 10'd26});
        exp_q.push_back({2'd2, 10'd200});
        wait_frames(2, 100);
        req_valid = '0;
        score("t4");

        // Mid-frame reset discards partial sum and returns pointer to 0
        do_reset();
        send(2, 8'd3);
        send(2, 8'd3);
        send(2, 8'd3);
        send(2, 8'd3);
        req_valid[2] = 1'b0;
        exp_q.push_back({2'd2, 10'd12});
        wait_frames(1, 20);
        score("t5_pre");
        send(0, 8'd100);
        send(0, 8'd100);
        rst_n     = 1'b0;
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        check("t5_rst_valid", valid_out, 0);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_ready", req_ready, 0);
        req_data[7:0]   = 8'd1;
        req_data[31:24] = 8'd2;
        req_valid[0] = 1'b1;
        req_valid[3] = 1'b1;
        exp_q.push_back({2'd0, 10'd4});
        exp_q.push_back({2'd3, 10'd8});
        wait_frames(2, 100);
        req_valid = '0;
        score("t5");

        // Idle with no requests
        do_reset();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("t6_busy", busy, 0);
            check("t6_ready", req_ready, 0);
            check("t6_valid_out", valid_out, 0);
        end
        score("t6");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
